// File: rtl/carwash_pkg.sv
// rtl/carwash_pkg.sv - shared types and default constants for the car wash timer unit
//
// Contents:
//   timer_state_t : per-timer FSM state (CLEAR, RUN, DONE), 2-bit encoding
//   CW_TICK_DIV   : default clock cycles per timer tick
//   CW_T1_TICKS   : default spray duration in ticks
//   CW_T2_TICKS   : default rinse duration in ticks
//   CW_CNT_W      : default width of prescaler and tick counters

package carwash_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

    localparam int CW_TICK_DIV = 1000;
    localparam int CW_T1_TICKS = 30;
    localparam int CW_T2_TICKS = 20;
    localparam int CW_CNT_W    = 16;

endpackage : carwash_pkg

// File: rtl/carwash_timer.sv
// rtl/carwash_timer.sv - single countdown timer: CLEAR/RUN/DONE FSM with prescaler and tick counter
//
// Optional feature macro: CARWASH_TIMER_PAUSE_EN (adds the PAUSE input).
//
// Parameters:
//   TICK_DIV : clock cycles per tick (>= 1)
//   TICKS    : timer duration in ticks (>= 1)
//   CNT_W    : prescaler / tick counter width
//
// Ports:
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   CLR   : clear/hold timer, active high, overrides everything
//   PAUSE : freeze a running timer, active high (CARWASH_TIMER_PAUSE_EN only)
//   DONE  : timer expired, registered

module carwash_timer
    import carwash_pkg::*;
#(
    parameter int TICK_DIV = CW_TICK_DIV,
    parameter int TICKS    = CW_T1_TICKS,
    parameter int CNT_W    = CW_CNT_W
) (
    input  logic clk,
    input  logic clr_n,
    input  logic CLR,
`ifdef CARWASH_TIMER_PAUSE_EN
    input  logic PAUSE,
`endif
    output logic DONE
);

    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TK_LAST  = CNT_W'(TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    timer_state_t     state;
    logic [CNT_W-1:0] sub;
    logic [CNT_W-1:0] tk;
    logic             done_q;
    logic             hold;

`ifdef CARWASH_TIMER_PAUSE_EN
    assign hold = PAUSE;
`else
    assign hold = 1'b0;
`endif

    // The enum literal DONE is hidden by the output port of the same name,
    // so state literals are referenced through the package scope.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= carwash_pkg::CLEAR;
            sub    <= '0;
            tk     <= '0;
            done_q <= 1'b0;
        end else if (CLR) begin
            state  <= carwash_pkg::CLEAR;
            sub    <= '0;
            tk     <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                carwash_pkg::CLEAR: begin
                    // Leaving CLEAR is edge 0; counting starts on the next edge.
                    state  <= carwash_pkg::RUN;
                    done_q <= 1'b0;
                end
                carwash_pkg::RUN: begin
                    if (!hold) begin
                        if (sub == SUB_LAST) begin
                            sub <= '0;
                            if (tk == TK_LAST) begin
                                // tk is left at its last value: counters freeze in DONE.
                                state  <= carwash_pkg::DONE;
                                done_q <= 1'b1;
                            end else begin
                                tk <= tk + CNT_ONE;
                            end
                        end else begin
                            sub <= sub + CNT_ONE;
                        end
                    end
                end
                carwash_pkg::DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= carwash_pkg::CLEAR;
                    sub    <= '0;
                    tk     <= '0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign DONE = done_q;

endmodule : carwash_timer

// File: rtl/carwash_timer_unit.sv
// rtl/carwash_timer_unit.sv - spray and rinse expiry timers for the car wash controller
//
// Optional feature macro: CARWASH_TIMER_PAUSE_EN (adds the PAUSE input).
//
// Parameters:
//   TICK_DIV : clock cycles per tick (>= 1), shared by both timers
//   T1_TICKS : spray duration in ticks (>= 1)
//   T2_TICKS : rinse duration in ticks (>= 1)
//   CNT_W    : prescaler / tick counter width
//
// Ports:
//   clk    : system clock, rising edge
//   clr_n  : asynchronous active-low reset
//   CLRT1  : clear/hold spray timer, active high
//   CLRT2  : clear/hold rinse timer, active high
//   PAUSE  : freeze running timers, active high (CARWASH_TIMER_PAUSE_EN only)
//   T1DONE : spray time expired, registered
//   T2DONE : rinse time expired, registered

module carwash_timer_unit
    import carwash_pkg::*;
#(
    parameter int TICK_DIV = CW_TICK_DIV,
    parameter int T1_TICKS = CW_T1_TICKS,
    parameter int T2_TICKS = CW_T2_TICKS,
    parameter int CNT_W    = CW_CNT_W
) (
    input  logic clk,
    input  logic clr_n,
    input  logic CLRT1,
    input  logic CLRT2,
`ifdef CARWASH_TIMER_PAUSE_EN
    input  logic PAUSE,
`endif
    output logic T1DONE,
    output logic T2DONE
);

    carwash_timer #(
        .TICK_DIV (TICK_DIV),
        .TICKS    (T1_TICKS),
        .CNT_W    (CNT_W)
    ) u_spray (
        .clk   (clk),
        .clr_n (clr_n),
        .CLR   (CLRT1),
`ifdef CARWASH_TIMER_PAUSE_EN
        .PAUSE (PAUSE),
`endif
        .DONE  (T1DONE)
    );

    carwash_timer #(
        .TICK_DIV (TICK_DIV),
        .TICKS    (T2_TICKS),
        .CNT_W    (CNT_W)
    ) u_rinse (
        .clk   (clk),
        .clr_n (clr_n),
        .CLR   (CLRT2),
`ifdef CARWASH_TIMER_PAUSE_EN
        .PAUSE (PAUSE),
`endif
        .DONE  (T2DONE)
    );

endmodule : carwash_timer_unit

// File: tb/tb_carwash_timer_unit.sv
// tb/tb_carwash_timer_unit.sv - self-checking bench for carwash_timer_unit (three parameter sets)

module tb_carwash_timer_unit;

    // dut_a: main test configuration, dut_b: TICK_DIV=1 boundary, dut_c: T_TICKS=1 boundary
    localparam int A_DIV = 4, A_T1 = 3, A_T2 = 2;
    localparam int B_DIV = 1, B_T1 = 5, B_T2 = 1;
    localparam int C_DIV = 3, C_T1 = 1, C_T2 = 2;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic CLRT1 = 1'b1;
    logic CLRT2 = 1'b1;
    logic PAUSE = 1'b0;
    logic a1, a2, b1, b2, c1, c2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    carwash_timer_unit #(.TICK_DIV(A_DIV), .T1_TICKS(A_T1), .T2_TICKS(A_T2), .CNT_W(16)) dut_a (
        .clk(clk), .clr_n(clr_n), .CLRT1(CLRT1), .CLRT2(CLRT2),
`ifdef CARWASH_TIMER_PAUSE_EN
        .PAUSE(PAUSE),
`endif
        .T1DONE(a1), .T2DONE(a2));

    carwash_timer_unit #(.TICK_DIV(B_DIV), .T1_TICKS(B_T1), .T2_TICKS(B_T2), .CNT_W(8)) dut_b (
        .clk(clk), .clr_n(clr_n), .CLRT1(CLRT1), .CLRT2(CLRT2),
`ifdef CARWASH_TIMER_PAUSE_EN
        .PAUSE(PAUSE),
`endif
        .T1DONE(b1), .T2DONE(b2));

    carwash_timer_unit #(.TICK_DIV(C_DIV), .T1_TICKS(C_T1), .T2_TICKS(C_T2), .CNT_W(4)) dut_c (
        .clk(clk), .clr_n(clr_n), .CLRT1(CLRT1), .CLRT2(CLRT2),
`ifdef CARWASH_TIMER_PAUSE_EN
        .PAUSE(PAUSE),
`endif
        .T1DONE(c1), .T2DONE(c2));

    // Behavioural model: a timer is armed by its first un-cleared edge, then
    // counts one per un-paused edge and expires when the count reaches N.
    int  n_tgt [6];
    bit  armed [6];
    int  elapsed [6];
    bit  mdone [6];
    logic pause_eff;

    initial begin
        n_tgt[0] = A_DIV * A_T1; n_tgt[1] = A_DIV * A_T2;
        n_tgt[2] = B_DIV * B_T1; n_tgt[3] = B_DIV * B_T2;
        n_tgt[4] = C_DIV * C_T1; n_tgt[5] = C_DIV * C_T2;
    end

`ifdef CARWASH_TIMER_PAUSE_EN
    assign pause_eff = PAUSE;
`else
    assign pause_eff = 1'b0;
`endif

    always @(posedge clk or negedge clr_n) begin
        for (int i = 0; i < 6; i++) begin
            if (!clr_n || ((i % 2 == 0) ? CLRT1 : CLRT2)) begin
                armed[i] = 1'b0;
                elapsed[i] = 0;
                mdone[i] = 1'b0;
            end else if (!armed[i]) begin
                armed[i] = 1'b1;
            end else if (!mdone[i] && !pause_eff) begin
                elapsed[i] = elapsed[i] + 1;
                if (elapsed[i] == n_tgt[i]) mdone[i] = 1'b1;
            end
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        logic got [6];
        got[0] = a1; got[1] = a2; got[2] = b1; got[3] = b2; got[4] = c1; got[5] = c2;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== mdone[i]) begin
                failures++;
                $display("FAIL model_out%0d got=%0b exp=%0b t=%0t", i, got[i], mdone[i], $time);
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        step(2);
        chk("reset_t1", a1, 1'b0);
        chk("reset_t2", a2, 1'b0);
        clr_n = 1'b1;
        step(2);

        // Basic expiry on timer 1; also pins TICK_DIV=1 and T_TICKS=1 cases
        CLRT1 = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            step(1);
            chk("basic_a1", a1, (k >= 12) ? 1'b1 : 1'b0);
            chk("basic_b1", b1, (k >= 5) ? 1'b1 : 1'b0);
            chk("basic_c1", c1, (k >= 3) ? 1'b1 : 1'b0);
        end
        step(20);
        chk("basic_hold", a1, 1'b1);
        CLRT1 = 1'b1;
        step(1);
        chk("basic_fall", a1, 1'b0);
        step(1);

        // Restart with a single-cycle pulse at edge 7
        CLRT1 = 1'b0;
        step(7);
        CLRT1 = 1'b1;
        step(1);
        CLRT1 = 1'b0;
        step(12);
        chk("restart_early", a1, 1'b0);
        step(1);
        chk("restart_rise", a1, 1'b1);
        CLRT1 = 1'b1;
        step(2);

        // Independence: timer 2 runs while timer 1 is held clear
        CLRT2 = 1'b0;
        step(8);
        chk("indep_t2_early", a2, 1'b0);
        step(1);
        chk("indep_t2_rise", a2, 1'b1);
        chk("indep_b2", b2, 1'b1);
        chk("indep_c2", c2, 1'b1);
        chk("indep_t1", a1, 1'b0);
        step(3);
        chk("indep_t1_late", a1, 1'b0);
        CLRT2 = 1'b1;
        step(2);

        // Asynchronous reset mid-run at edge 6, then mid-cycle reset check
        CLRT1 = 1'b0;
        step(7);
        #2 clr_n = 1'b0;
        #1 chk("async_rst_t1", a1, 1'b0);
        step(1);
        clr_n = 1'b1;
        step(12);
        chk("rstrun_early", a1, 1'b0);
        step(1);
        chk("rstrun_rise", a1, 1'b1);
        #2 clr_n = 1'b0;
        #1 chk("async_rst_done", a1, 1'b0);
        chk("async_rst_b1", b1, 1'b0);
        step(1);
        clr_n = 1'b1;
        CLRT1 = 1'b1;
        step(2);

`ifdef CARWASH_TIMER_PAUSE_EN
        // PAUSE for 5 cycles from edge 3 stretches expiry to edge 17
        CLRT1 = 1'b0;
        step(3);
        PAUSE = 1'b1;
        step(5);
        PAUSE = 1'b0;
        step(9);
        chk("pause_early", a1, 1'b0);
        step(1);
        chk("pause_rise", a1, 1'b1);
        // CLRT1 wins over PAUSE
        PAUSE = 1'b1;
        CLRT1 = 1'b1;
        step(1);
        chk("pause_clr", a1, 1'b0);
        CLRT1 = 1'b0;
        PAUSE = 1'b0;
        step(13);
        chk("pause_clr_rise", a1, 1'b1);
        CLRT1 = 1'b1;
        step(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_carwash_timer_unit
